// File: rtl/pc_next_mux_pkg.sv
// pc_next_mux_pkg: constants shared by the program-counter path.
//   ADDR_W       - address width used by the PC, adders and next-PC mux.
//   RESET_VECTOR - address the PC starts from after reset.
//   is_misaligned - helper returning whether the low align_bits of an
//                   address are not all zero.
package pc_next_mux_pkg;

  localparam int ADDR_W = 32;
  localparam logic [ADDR_W-1:0] RESET_VECTOR = '0;

  // Source selected by the next-PC mux.
  typedef enum logic {
    SRC_SEQ    = 1'b0,  // PC+4
    SRC_BRANCH = 1'b1   // branch target
  } pc_src_e;

  function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr,
                                         input int align_bits);
    logic flag;
    flag = 1'b0;
    for (int i = 0; i < ADDR_W; i++) begin
      if (i < align_bits) flag = flag | addr[i];
    end
    return flag;
  endfunction

endpackage

// File: rtl/pc_next_mux_mux2.sv
// mux2: parameterized combinational 2:1 selector, shared by the next-PC,
// ALU-source and write-back paths.
//   in0 - selected when sel = 0
//   in1 - selected when sel = 1
//   sel - select
//   out - selected value
module mux2 #(
  parameter int W = 32
) (
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic         sel,
  output logic [W-1:0] out
);

  assign out = sel ? in1 : in0;

endmodule

// File: rtl/pc_next_mux.sv
// pc_next_mux: registered next-address selector for the LEGv8 PC stage.
// Picks PC+4 (adder_1) or the branch target (adder_2), registers it, and
// records which source was taken plus a word-misalignment flag.
//   clk           - clock, rising edge
//   rst_n         - asynchronous active-low reset
//   en            - update enable; 0 holds every register
//   adder_1       - sequential address, chosen when mux_1_control = 0
//   adder_2       - branch target, chosen when mux_1_control = 1
//   mux_1_control - source select (branch taken)
//   data_out      - registered selected address
//   src_taken     - registered select for the value in data_out
//   misaligned    - registered: low ALIGN_BITS bits of data_out not all zero
module pc_next_mux
  import pc_next_mux_pkg::*;
#(
  parameter int                WIDTH       = ADDR_W,
  parameter logic [WIDTH-1:0]  RESET_VALUE = RESET_VECTOR,
  parameter int                ALIGN_BITS  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] adder_1,
  input  logic [WIDTH-1:0] adder_2,
  input  logic             mux_1_control,
  output logic [WIDTH-1:0] data_out,
  output logic             src_taken,
  output logic             misaligned
);

  logic [WIDTH-1:0] sel;
  logic             sel_misaligned;

  logic [WIDTH-1:0] data_d, data_q;
  logic             src_d, src_q;
  logic             mis_d, mis_q;

  mux2 #(.W(WIDTH)) u_mux2 (
    .in0 (adder_1),
    .in1 (adder_2),
    .sel (mux_1_control),
    .out (sel)
  );

  // ALIGN_BITS = 0 turns the check off entirely.
  generate
    if (ALIGN_BITS == 0) begin : g_no_align
      assign sel_misaligned = 1'b0;
    end else begin : g_align
      assign sel_misaligned = |sel[ALIGN_BITS-1:0];
    end
  endgenerate

  always_comb begin
    data_d = data_q;
    src_d  = src_q;
    mis_d  = mis_q;
    if (en) begin
      data_d = sel;
      src_d  = mux_1_control;
      mis_d  = sel_misaligned;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= RESET_VALUE;
      src_q  <= 1'b0;
      mis_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      src_q  <= src_d;
      mis_q  <= mis_d;
    end
  end

  assign data_out   = data_q;
  assign src_taken  = src_q;
  assign misaligned = mis_q;

endmodule

// File: tb/tb_pc_next_mux.sv
// tb_pc_next_mux: self-checking bench for pc_next_mux with directed
// scenarios and randomized traffic against a behavioural model.
module tb_pc_next_mux;

  localparam int W     = 32;
  localparam int ALIGN = 2;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [W-1:0] adder_1;
  logic [W-1:0] adder_2;
  logic         mux_1_control;
  logic [W-1:0] data_out;
  logic         src_taken;
  logic         misaligned;

  int n_checks;
  int n_fail;

  // Reference model state: what the outputs must show.
  logic [W-1:0] exp_data;
  logic         exp_src;
  logic         exp_mis;

  pc_next_mux #(
    .WIDTH       (W),
    .RESET_VALUE ('0),
    .ALIGN_BITS  (ALIGN)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .adder_1       (adder_1),
    .adder_2       (adder_2),
    .mux_1_control (mux_1_control),
    .data_out      (data_out),
    .src_taken     (src_taken),
    .misaligned    (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    exp_data = '0;
    exp_src  = 1'b0;
    exp_mis  = 1'b0;
  endfunction

  // Advance one clock edge, updating the model from the inputs present at
  // the edge, then settle 1 ns after the edge.
  task automatic tick();
    longint unsigned picked;
    if ($isunknown(mux_1_control)) begin
      n_fail++;
      $display("FAIL select_known: mux_1_control=%b required known", mux_1_control);
    end
    n_checks++;
    @(posedge clk);
    if (rst_n && en) begin
      picked   = mux_1_control ? longint'(adder_2) : longint'(adder_1);
      exp_data = picked[W-1:0];
      exp_src  = mux_1_control;
      exp_mis  = (picked % (64'd1 << ALIGN)) != 0;
    end
    #1;
    $display("t=%0t en=%b ctl=%b a1=%h a2=%h -> out=%h src=%b mis=%b",
             $time, en, mux_1_control, adder_1, adder_2, data_out, src_taken, misaligned);
  endtask

  task automatic drive(input logic e, input logic c,
                       input logic [W-1:0] a1, input logic [W-1:0] a2);
    en = e; mux_1_control = c; adder_1 = a1; adder_2 = a2;
  endtask

  task automatic test_reset();
    // Bring rst_n low before the first clock edge (first posedge at 5 ns).
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 32'h4, 32'h100);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({data_out, src_taken, misaligned} !== {32'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_async: got %h/%b/%b want 00000000/0/0",
               data_out, src_taken, misaligned);
    end
    // Reset dominates en across edges.
    tick(); tick();
    model_reset();
    n_checks++;
    if ({data_out, src_taken, misaligned} !== {exp_data, exp_src, exp_mis}) begin
      n_fail++;
      $display("FAIL reset_hold: got %h/%b/%b want %h/%b/%b",
               data_out, src_taken, misaligned, exp_data, exp_src, exp_mis);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    drive(1'b1, 1'b0, 32'h4, 32'h80);
    tick();
    n_checks++;
    if ({data_out, src_taken, misaligned} !== {32'h4, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL sequential: got %h/%b/%b want 00000004/0/0",
               data_out, src_taken, misaligned);
    end
  endtask

  task automatic test_branch();
    drive(1'b1, 1'b1, 32'h4, 32'h80);
    tick();
    n_checks++;
    if ({data_out, src_taken, misaligned} !== {32'h80, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL branch: got %h/%b/%b want 00000080/1/0",
               data_out, src_taken, misaligned);
    end
    mux_1_control = 1'b0;
    tick();
    n_checks++;
    if ({data_out, src_taken} !== {32'h4, 1'b0}) begin
      n_fail++;
      $display("FAIL branch_return: got %h/%b want 00000004/0", data_out, src_taken);
    end
  endtask

  task automatic test_stall();
    drive(1'b1, 1'b1, 32'h4, 32'h80);
    tick();
    drive(1'b0, 1'b1, 32'h4, 32'hFFFF_FFFC);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({data_out, src_taken, misaligned} !== {32'h80, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got %h/%b/%b want 00000080/1/0",
                 i, data_out, src_taken, misaligned);
      end
      mux_1_control = ~mux_1_control;  // toggling during a stall is ignored
    end
    drive(1'b1, 1'b1, 32'h4, 32'hFFFF_FFFC);
    tick();
    n_checks++;
    if (data_out !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL stall_release: got %h want fffffffc", data_out);
    end
  endtask

  task automatic test_misalign();
    drive(1'b1, 1'b1, 32'h4, 32'h102);
    tick();
    n_checks++;
    if ({data_out, misaligned} !== {32'h102, 1'b1}) begin
      n_fail++;
      $display("FAIL misalign_branch: got %h/%b want 00000102/1", data_out, misaligned);
    end
    drive(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h102);
    tick();
    n_checks++;
    if ({data_out, src_taken, misaligned} !== {32'hFFFF_FFFF, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL all_ones: got %h/%b/%b want ffffffff/0/1",
               data_out, src_taken, misaligned);
    end
    adder_1 = 32'h0;
    tick();
    n_checks++;
    if ({data_out, misaligned} !== {32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL all_zeros: got %h/%b want 00000000/0", data_out, misaligned);
    end
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 1'b1, 32'h4, 32'h80);
    tick();                    // captured 0x80, now 1 ns after the edge
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({data_out, src_taken, misaligned} !== {32'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_reset: got %h/%b/%b want 00000000/0/0",
               data_out, src_taken, misaligned);
    end
    #2 rst_n = 1'b1;           // 3 ns pulse, released well before the next edge
    drive(1'b1, 1'b0, 32'h0000_0010, 32'h80);
    tick();
    n_checks++;
    if ({data_out, src_taken, misaligned} !== {32'h10, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL post_reset_capture: got %h/%b/%b want 00000010/0/0",
               data_out, src_taken, misaligned);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] hold_data;
    for (int i = 0; i < 150; i++) begin
      drive(($urandom_range(0, 3) != 0), 1'($urandom), $urandom, $urandom);
      if ($urandom_range(0, 9) == 0) begin
        adder_1 = 32'hFFFF_FFFF;
        adder_2 = 32'h0;
      end
      tick();
      n_checks++;
      if ({data_out, src_taken, misaligned} !== {exp_data, exp_src, exp_mis}) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h/%b/%b want %h/%b/%b", i,
                 data_out, src_taken, misaligned, exp_data, exp_src, exp_mis);
      end
      // Inputs changing between edges must not reach the outputs.
      hold_data = data_out;
      drive(1'b1, ~mux_1_control, ~adder_1, ~adder_2);
      #1;
      n_checks++;
      if (data_out !== exp_data || hold_data !== exp_data) begin
        n_fail++;
        $display("FAIL no_comb_path[%0d]: got %h want %h", i, data_out, exp_data);
      end
    end
  endtask

  task automatic test_back_to_back();
    // Select and data change together every cycle; each edge must capture
    // the coherent pair.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, i[0], 32'h1000 + 32'(4 * i), 32'h8000 + 32'(i));
      tick();
      n_checks++;
      if ({data_out, src_taken, misaligned} !== {exp_data, exp_src, exp_mis}) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got %h/%b/%b want %h/%b/%b", i,
                 data_out, src_taken, misaligned, exp_data, exp_src, exp_mis);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_sequential();
    test_branch();
    test_stall();
    test_misalign();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_next_mux.md
Name: pc_next_mux

Overview:
- Registered 2:1 next-address selector for the LEGv8 datapath.
- Chooses between the sequential address from adder_1 (PC+4) and the branch target from adder_2 (PC + offset), using mux_1_control.
- Registers the result for the program-counter stage.
- Also reports which source was taken and flags word-misaligned results.

Parameters:
- WIDTH, 32, data width of both inputs and of data_out.
- RESET_VALUE, 0, value loaded into data_out on reset.
- ALIGN_BITS, 2, number of low-order bits that must be zero for a word-aligned address. Range 0..WIDTH-1. A value of 0 disables the misalignment check.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  update enable. 0 means stall: all registers hold.
- adder_1  in  WIDTH  sequential address (PC+4); selected when mux_1_control=0.
- adder_2  in  WIDTH  branch target; selected when mux_1_control=1.
- mux_1_control  in  1  source select (branch taken).
- data_out  out  WIDTH  registered selected address.
- src_taken  out  1  registered copy of mux_1_control for the last captured value.
- misaligned  out  1  registered flag: the low ALIGN_BITS bits of the captured value were not all zero.

Behaviour:
- Reset:
  - Asynchronous assertion whenever rst_n=0, independent of clk.
  - During reset: data_out=RESET_VALUE, src_taken=0, misaligned=0.
  - Reset dominates en and all data inputs.
  - Deassertion is sampled at the next rising clk edge. The first capture can occur on the first rising edge with rst_n=1 and en=1.
- Selection (combinational, internal): sel = mux_1_control ? adder_2 : adder_1.
- Capture: on a rising edge with rst_n=1 and en=1:
  - data_out <= sel
  - src_taken <= mux_1_control
  - misaligned <= OR of sel[ALIGN_BITS-1:0]; 0 when ALIGN_BITS=0.
- Stall: en=0 holds all three outputs. Input changes during a stall have no effect.
- Latency: exactly one cycle from input to data_out. No combinational path from the inputs to any output.
- Width: no arithmetic; values pass through bit-exact with no truncation or extension. All-ones and all-zeros pass unchanged.
- Simultaneous events: a mux_1_control change and an input data change in the same cycle are both captured coherently at the same edge.
- Reset mid-operation: asserting rst_n low between edges forces the reset values immediately. A pending capture is discarded.
- Misalignment handling: misaligned is informational only and never blocks the capture.
- Unknown select: an X/Z on mux_1_control is a simulation-only condition. The implementation must not add logic to handle it. The bench must flag it as an error.

Decomposition:
- Shared package: WIDTH default (ADDR_W=32) and the reset-vector constant, both used by the PC and adder blocks.
- One natural sub-module: mux2, a parameterized combinational 2:1 selector. It is reused elsewhere in the datapath (ALU-source and write-back muxes).
- The flop stage and the misalignment logic remain in pc_next_mux.

Test Plan:
- Reset: rst_n=0 with adder_1=0x4, adder_2=0x100, mux_1_control=1 -> data_out=0x0, src_taken=0, misaligned=0, asynchronously and before any clk edge.
- Sequential path: adder_1=0x00000004, adder_2=0x00000080, mux_1_control=0, en=1 -> after 1 edge, data_out=0x00000004, src_taken=0, misaligned=0.
- Branch path: same inputs with mux_1_control=1 -> after 1 edge, data_out=0x00000080, src_taken=1. Then mux_1_control=0 -> next edge, data_out=0x00000004.
- Stall: capture 0x80, then set en=0 and change adder_2=0xFFFFFFFC for 3 edges -> data_out stays 0x80. Set en=1 -> next edge, data_out=0xFFFFFFFC.
- Misalignment and extremes: adder_2=0x00000102, mux_1_control=1 -> data_out=0x102, misaligned=1. Then adder_1=0xFFFFFFFF, mux_1_control=0 -> data_out=0xFFFFFFFF, misaligned=1. Then adder_1=0x0 -> misaligned=0.
- Mid-cycle reset: after capturing 0x80, pulse rst_n low for 3 ns between edges -> data_out=0 immediately. After release, the first enabled edge captures the current selection.
